// File: rtl/gmsk_pkg.sv
// Shared constants, Gaussian tap table and types for the GMSK frequency shaper.
package gmsk_pkg;

    localparam int SPS   = 8;
    localparam int F_DEV = 16;
    localparam int TAPS  = 3 * SPS;

    typedef logic [4:0] tap_t;

    // Symmetric Gaussian taps; each column G[k], G[k+8], G[k+16] sums to F_DEV.
    localparam tap_t G [0:TAPS-1] = '{
        5'd0,  5'd0,  5'd0,  5'd1,  5'd1,  5'd2,  5'd3,  5'd4,
        5'd12, 5'd13, 5'd14, 5'd14, 5'd14, 5'd14, 5'd13, 5'd12,
        5'd4,  5'd3,  5'd2,  5'd1,  5'd1,  5'd0,  5'd0,  5'd0
    };

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    typedef struct packed {
        logic s_prev;
        logic s_cur;
        logic s_next;
    } window_t;

    function automatic logic signed [6:0] signed_tap(input logic a, input tap_t g);
        logic signed [6:0] mag;
        mag = $signed({2'b00, g});
        return a ? mag : -mag;
    endfunction

endpackage

// File: rtl/gmsk_freq_shaper_if.sv
// Serial NRZ bit handshake between the bit source and the frequency shaper.
interface gmsk_freq_shaper_if;

    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );

endinterface

// File: rtl/gmsk_pulse_sum.sv
// Combinational Gaussian pulse sum: three-symbol window and sample index to a
// saturated 8-bit DDS frequency word.
module gmsk_pulse_sum
    import gmsk_pkg::*;
(
    input  window_t    win,
    input  logic [2:0] k,
    input  logic [7:0] f_center,
    output logic [7:0] word
);

    logic signed [6:0] dev;
    logic signed [9:0] sum;

    // NOTE: every always_comb output is assigned on every path, otherwise a latch is inferred.
    always_comb begin
        dev = signed_tap(win.s_prev, G[{2'b10, k}])
            + signed_tap(win.s_cur,  G[{2'b01, k}])
            + signed_tap(win.s_next, G[{2'b00, k}]);
        sum = $signed({2'b00, f_center}) + $signed({{3{dev[6]}}, dev});
        if (sum < 0) begin
            word = 8'd0;
        end else if (sum > 10'sd255) begin
            word = 8'hFF;
        end else begin
            word = sum[7:0];
        end
    end

endmodule

// File: rtl/gmsk_freq_shaper.sv
// GMSK transmit front end: bit handshake, symbol window FSM and registered
// frequency word / DDS enable outputs.
module gmsk_freq_shaper
    import gmsk_pkg::*;
#(
    parameter logic [7:0] F_CENTER = 8'd64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_en,
    gmsk_freq_shaper_if.slave         bit_if,
    output logic [7:0]                f_word,
    output logic                      wave_en,
    output logic                      underrun,
    output logic                      busy
);

    localparam logic [2:0] K_LAST = 3'(SPS - 1);

    state_t     state;
    logic [2:0] k;
    window_t    win;

    logic       at_boundary;
    logic       accept;
    logic       new_bit;
    logic [7:0] sum_word;

    assign at_boundary = (k == K_LAST);
    assign accept      = bit_if.bit_valid & bit_if.bit_ready;
    // A missing bit at a boundary repeats the previous look-ahead symbol.
    assign new_bit     = accept ? bit_if.bit_in : win.s_next;
    assign busy        = (state != IDLE);
    assign underrun    = (state == RUN) & at_boundary & tx_en & ~bit_if.bit_valid;

    always_comb begin
        bit_if.bit_ready = 1'b0;
        case (state)
            IDLE:    bit_if.bit_ready = tx_en;
            FILL:    bit_if.bit_ready = 1'b1;
            RUN:     bit_if.bit_ready = tx_en & at_boundary;
            default: bit_if.bit_ready = 1'b0;
        endcase
    end

    gmsk_pulse_sum u_pulse_sum (
        .win      (win),
        .k        (k),
        .f_center (F_CENTER),
        .word     (sum_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= 3'd0;
            win     <= '0;
            f_word  <= 8'd0;
            wave_en <= 1'b0;
        end else begin
            f_word  <= 8'd0;
            wave_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        win.s_prev <= bit_if.bit_in;
                        win.s_cur  <= bit_if.bit_in;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        win.s_next <= bit_if.bit_in;
                        k          <= 3'd0;
                        state      <= RUN;
                    end else if (!tx_en) begin
                        win.s_next <= win.s_cur;
                        k          <= 3'd0;
                        state      <= FLUSH;
                    end
                end
                RUN: begin
                    f_word  <= sum_word;
                    wave_en <= 1'b1;
                    k       <= k + 3'd1;
                    if (at_boundary) begin
                        win.s_prev <= win.s_cur;
                        win.s_cur  <= win.s_next;
                        win.s_next <= new_bit;
                        if (!tx_en) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Last symbol plays out with the look-ahead bit frozen.
                    f_word  <= sum_word;
                    wave_en <= 1'b1;
                    k       <= k + 3'd1;
                    if (at_boundary) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmsk_freq_shaper.sv
// Scoreboard bench for gmsk_freq_shaper: symbol-level reference model feeds an
// expected-sample queue that a free-running monitor drains.
module tb_gmsk_freq_shaper;

    localparam int FC  = 64;
    localparam int SPS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] f_word;
    logic       wave_en;
    logic       underrun;
    logic       busy;

    gmsk_freq_shaper_if bif ();

    gmsk_freq_shaper #(.F_CENTER(8'(FC))) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .bit_if   (bif),
        .f_word   (f_word),
        .wave_en  (wave_en),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference Gaussian taps, kept independently of the design package.
    int g_ref [24] = '{0, 0, 0, 1, 1, 2, 3, 4,
                       12, 13, 14, 14, 14, 14, 13, 12,
                       4, 3, 2, 1, 1, 0, 0, 0};

    int total;
    int bad;

    int exp_q[$];
    int len_q[$];
    int ur_exp;
    int ur_seen;

    logic m_prev;
    logic m_last;
    bit   m_have;
    int   m_count;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int lvl(input logic b);
        return b ? 1 : -1;
    endfunction

    // One symbol of samples: centre c, neighbours p (before) and n (after).
    task automatic push_symbol(input logic p, input logic c, input logic n);
        int f;
        for (int kk = 0; kk < SPS; kk++) begin
            f = FC + lvl(p) * g_ref[kk + 16] + lvl(c) * g_ref[kk + 8] + lvl(n) * g_ref[kk];
            if (f < 0) f = 0;
            if (f > 255) f = 255;
            exp_q.push_back(f);
        end
    endtask

    // Appending a symbol completes the previous one, whose look-ahead is now known.
    task automatic append(input logic x);
        if (m_have) begin
            push_symbol(m_prev, m_last, x);
            m_prev = m_last;
        end else begin
            m_prev = x;
        end
        m_last = x;
        m_have = 1'b1;
        m_count++;
    endtask

    task automatic end_burst();
        if (m_have) begin
            push_symbol(m_prev, m_last, m_last);
            len_q.push_back(SPS * m_count);
        end
        m_have  = 1'b0;
        m_count = 0;
    endtask

    task automatic send_bit(input logic b, output bit ok);
        ok = 1'b0;
        bif.bit_in    = b;
        bif.bit_valid = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (bif.bit_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bif.bit_valid = 1'b0;
    endtask

    task automatic miss_boundary();
        bit seen;
        seen = 1'b0;
        bif.bit_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bif.bit_ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("gap_boundary_seen", int'(seen), 1);
        if (seen) begin
            append(m_last);
            ur_exp++;
        end
    endtask

    task automatic wait_idle(input bit chk_ready);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (chk_ready) check("bit_ready_after_drop", int'(bif.bit_ready), 0);
            if (!busy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("burst_end_idle", int'(done), 1);
    endtask

    // mode: 0 all ones, 1 all zeros, 2 alternating, 3 random
    task automatic run_burst(input int n, input int mode, input int gap_at, input bit valid_at_drop);
        logic b;
        bit   ok;
        m_have  = 1'b0;
        m_count = 0;
        tx_en   = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i >= 2 && i == gap_at) miss_boundary();
            case (mode)
                0:       b = 1'b1;
                1:       b = 1'b0;
                2:       b = (i % 2 == 0);
                default: b = 1'($urandom_range(0, 1));
            endcase
            send_bit(b, ok);
            check("bit_accept", int'(ok), 1);
            append(b);
        end
        if (valid_at_drop && n >= 2) begin
            bif.bit_in    = 1'($urandom_range(0, 1));
            bif.bit_valid = 1'b1;
        end
        tx_en = 1'b0;
        end_burst();
        wait_idle(n >= 2);
        bif.bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_run();
        bit ok;
        m_have  = 1'b0;
        m_count = 0;
        tx_en   = 1'b1;
        send_bit(1'b1, ok);
        check("rst_test_b0", int'(ok), 1);
        append(1'b1);
        send_bit(1'b0, ok);
        check("rst_test_b1", int'(ok), 1);
        append(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        tx_en = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_wave_en", int'(wave_en), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_f_word", int'(f_word), 0);
        check("mid_reset_wave_en", int'(wave_en), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_bit_ready", int'(bif.bit_ready), 0);
        m_have  = 1'b0;
        m_count = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        int   run_len;
        logic ur_d;
        run_len = 0;
        ur_d    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                len_q.delete();
                run_len = 0;
                ur_d    = 1'b0;
            end else begin
                if (wave_en) begin
                    run_len++;
                    if (exp_q.size() == 0) fail_now("f_word_unexpected_sample");
                    else check("f_word", int'(f_word), exp_q.pop_front());
                end else begin
                    check("f_word_when_gated", int'(f_word), 0);
                    if (run_len > 0) begin
                        if (len_q.size() == 0) fail_now("wave_en_unexpected_run");
                        else check("wave_en_run_len", run_len, len_q.pop_front());
                        run_len = 0;
                    end
                end
                if (underrun) ur_seen++;
                if (underrun && ur_d) fail_now("underrun_wider_than_one_cycle");
                ur_d = underrun;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        int gap;
        total   = 0;
        bad     = 0;
        ur_exp  = 0;
        ur_seen = 0;
        m_have  = 1'b0;
        m_count = 0;
        bif.bit_in    = 1'b0;
        bif.bit_valid = 1'b0;
        rst   = 1'b1;
        tx_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_f_word", int'(f_word), 0);
        check("reset_wave_en", int'(wave_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_underrun", int'(underrun), 0);
        check("reset_bit_ready", int'(bif.bit_ready), 0);
        @(posedge clk);
        #1;

        run_burst(32, 0, -1, 1'b0);   // steady +tone
        run_burst(10, 1, -1, 1'b0);   // steady -tone
        run_burst(16, 2, -1, 1'b1);   // alternating, bit offered at drop
        run_burst(12, 3, 5, 1'b0);    // one missed boundary mid-burst
        run_burst(1, 3, -1, 1'b0);    // tx_en dropped in FILL
        reset_mid_run();

        for (int t = 0; t < 20; t++) begin
            n   = $urandom_range(1, 12);
            gap = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(2, 11);
            run_burst(n, 3, gap, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("run_lengths_drained", len_q.size(), 0);
        check("underrun_count", ur_seen, ur_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
